// File: rtl/nn_train_sequencer_if.sv
// nn_train_sequencer_if: control/status bundle between the training sequencer
// (master) and the pattern/data block plus architecture side (slave).
// Carries the run request, the published sample/epoch counts, the result
// strobe from the architecture, the five phase strobes and the progress status.
interface nn_train_sequencer_if #(
    parameter int BITS = 16
) ();

    logic            GO;
    logic [BITS-1:0] TRAIN;
    logic [BITS-1:0] VALID;
    logic [BITS-1:0] EPOCH;
    logic            res_v;
    logic            res_err;
    logic            START;
    logic            TR;
    logic            VL;
    logic            SW;
    logic            END;
    logic            busy;
    logic [BITS-1:0] epoch_cnt;
    logic [BITS-1:0] val_err;
    logic            early_stop;

    modport master (
        input  GO, TRAIN, VALID, EPOCH, res_v, res_err,
        output START, TR, VL, SW, END, busy, epoch_cnt, val_err, early_stop
    );

    modport slave (
        output GO, TRAIN, VALID, EPOCH, res_v, res_err,
        input  START, TR, VL, SW, END, busy, epoch_cnt, val_err, early_stop
    );

endinterface

// File: rtl/nn_train_sequencer.sv
// nn_train_sequencer: steps the data block through training and validation
// samples, epoch by epoch, with single-cycle registered strobes
// (START, TR, VL, SW, END). Each sample occupies SAMPLE_CYC cycles; the
// strobe marks slot 0 of the sample. Validation errors reported by the
// architecture are counted (saturating) per epoch.
// Optional feature macro: NN_EARLY_STOP_EN -- ends the run after an epoch
// whose validation pass produced zero errors and reports it on early_stop.
module nn_train_sequencer #(
    parameter int BITS       = 16,
    parameter int SAMPLE_CYC = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    nn_train_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        STRT  = 3'd1,
        TRN   = 3'd2,
        VAL   = 3'd3,
        STORE = 3'd4,
        FIN   = 3'd5
    } state_t;

    localparam logic [7:0]      SLOT_LAST = 8'(SAMPLE_CYC - 1);
    localparam logic [BITS-1:0] CNT_ZERO  = {BITS{1'b0}};
    localparam logic [BITS-1:0] CNT_ONE   = BITS'(1);
    localparam logic [BITS-1:0] CNT_MAX   = {BITS{1'b1}};

    state_t          state_r;
    state_t          state_s;
    logic [7:0]      slot_r;
    logic [7:0]      slot_s;
    logic [BITS-1:0] samp_r;
    logic [BITS-1:0] samp_s;

    logic [BITS-1:0] train_r;
    logic [BITS-1:0] valid_r;
    logic [BITS-1:0] epoch_r;

    logic [BITS-1:0] epoch_cnt_r;
    logic [BITS-1:0] val_err_r;
    logic            early_stop_r;
    logic            es_hit_s;
    logic            es_take_s;

    logic            start_r;
    logic            tr_r;
    logic            vl_r;
    logic            sw_r;
    logic            end_r;
    logic            busy_r;

    // First sample phase of an epoch: training if any, else validation,
    // else straight to the weight store.
    function automatic state_t first_phase(input logic [BITS-1:0] t,
                                           input logic [BITS-1:0] v);
        state_t ph;
        if (t != CNT_ZERO) begin
            ph = TRN;
        end else if (v != CNT_ZERO) begin
            ph = VAL;
        end else begin
            ph = STORE;
        end
        return ph;
    endfunction

`ifdef NN_EARLY_STOP_EN
    assign es_hit_s = (valid_r != CNT_ZERO) && (val_err_r == CNT_ZERO);
`else
    assign es_hit_s = 1'b0;
`endif

    // Next-state, slot and sample counter logic of the run sequencer.
    always_comb begin
        state_s   = state_r;
        slot_s    = slot_r;
        samp_s    = samp_r;
        es_take_s = 1'b0;
        case (state_r)
            IDLE: begin
                slot_s = 8'd0;
                samp_s = CNT_ZERO;
                if (bus.GO) begin
                    state_s = STRT;
                end else begin
                    state_s = IDLE;
                end
            end
            STRT: begin
                if (epoch_r == CNT_ZERO) begin
                    state_s = FIN;
                end else begin
                    state_s = first_phase(train_r, valid_r);
                end
            end
            TRN: begin
                if (slot_r == SLOT_LAST) begin
                    slot_s = 8'd0;
                    if (samp_r == (train_r - CNT_ONE)) begin
                        samp_s = CNT_ZERO;
                        if (valid_r != CNT_ZERO) begin
                            state_s = VAL;
                        end else begin
                            state_s = STORE;
                        end
                    end else begin
                        samp_s = samp_r + CNT_ONE;
                    end
                end else begin
                    slot_s = slot_r + 8'd1;
                end
            end
            VAL: begin
                if (slot_r == SLOT_LAST) begin
                    slot_s = 8'd0;
                    if (samp_r == (valid_r - CNT_ONE)) begin
                        samp_s  = CNT_ZERO;
                        state_s = STORE;
                    end else begin
                        samp_s = samp_r + CNT_ONE;
                    end
                end else begin
                    slot_s = slot_r + 8'd1;
                end
            end
            STORE: begin
                // epoch_cnt_r already holds the incremented count here
                if (es_hit_s) begin
                    state_s   = FIN;
                    es_take_s = 1'b1;
                end else if (epoch_cnt_r == epoch_r) begin
                    state_s = FIN;
                end else begin
                    state_s = first_phase(train_r, valid_r);
                end
            end
            FIN: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                slot_s  = 8'd0;
                samp_s  = CNT_ZERO;
            end
        endcase
    end

    // State, slot and sample counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            slot_r  <= 8'd0;
            samp_r  <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            slot_r  <= slot_s;
            samp_r  <= samp_s;
        end
    end

    // Run limits are captured when a run is accepted and held until IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            train_r <= CNT_ZERO;
            valid_r <= CNT_ZERO;
            epoch_r <= CNT_ZERO;
        end else if ((state_r == IDLE) && bus.GO) begin
            train_r <= bus.TRAIN;
            valid_r <= bus.VALID;
            epoch_r <= bus.EPOCH;
        end else begin
            train_r <= train_r;
            valid_r <= valid_r;
            epoch_r <= epoch_r;
        end
    end

    // Completed-epoch counter: cleared entering START, bumped entering STORE.
    always_ff @(posedge clk) begin
        if (rst) begin
            epoch_cnt_r <= CNT_ZERO;
        end else if (state_s == STRT) begin
            epoch_cnt_r <= CNT_ZERO;
        end else if (state_s == STORE) begin
            epoch_cnt_r <= epoch_cnt_r + CNT_ONE;
        end else begin
            epoch_cnt_r <= epoch_cnt_r;
        end
    end

    // Validation error counter: cleared per run and per validation pass,
    // counts qualified errors only while validating, saturates at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            val_err_r <= CNT_ZERO;
        end else if (state_s == STRT) begin
            val_err_r <= CNT_ZERO;
        end else if ((state_r != VAL) && (state_s == VAL)) begin
            val_err_r <= CNT_ZERO;
        end else if ((state_r == VAL) && bus.res_v && bus.res_err &&
                     (val_err_r != CNT_MAX)) begin
            val_err_r <= val_err_r + CNT_ONE;
        end else begin
            val_err_r <= val_err_r;
        end
    end

    // Early-stop flag: set on the early exit from STORE, held until next run.
    always_ff @(posedge clk) begin
        if (rst) begin
            early_stop_r <= 1'b0;
        end else if (state_s == STRT) begin
            early_stop_r <= 1'b0;
        end else if (es_take_s) begin
            early_stop_r <= 1'b1;
        end else begin
            early_stop_r <= early_stop_r;
        end
    end

    // Strobes and busy are decoded from the next state so they are flop outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_r <= 1'b0;
            tr_r    <= 1'b0;
            vl_r    <= 1'b0;
            sw_r    <= 1'b0;
            end_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            start_r <= (state_s == STRT);
            tr_r    <= (state_s == TRN) && (slot_s == 8'd0);
            vl_r    <= (state_s == VAL) && (slot_s == 8'd0);
            sw_r    <= (state_s == STORE);
            end_r   <= (state_s == FIN);
            busy_r  <= (state_s != IDLE);
        end
    end

    assign bus.START      = start_r;
    assign bus.TR         = tr_r;
    assign bus.VL         = vl_r;
    assign bus.SW         = sw_r;
    assign bus.END        = end_r;
    assign bus.busy       = busy_r;
    assign bus.epoch_cnt  = epoch_cnt_r;
    assign bus.val_err    = val_err_r;
    assign bus.early_stop = early_stop_r;

endmodule

// File: tb/tb_nn_train_sequencer.sv
// tb_nn_train_sequencer: three sequencer instances (S=4/BITS=16, S=1/BITS=16,
// S=2/BITS=4) share clock, reset and stimulus; one is selected per run. The
// expected strobe timeline is built from the epoch/sample arithmetic and
// compared cycle by cycle.
module tb_nn_train_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic [15:0] tr_in;
    logic [15:0] vl_in;
    logic [15:0] ep_in;
    logic        res_v;
    logic        res_err;
    int          sel;

    int n_checks = 0;
    int n_fail   = 0;

    int exp_code [0:1023];
    bit rv_a     [0:1023];
    bit re_a     [0:1023];

    logic [4:0]  obs_strb;
    logic        obs_busy;
    logic        obs_es;
    logic [15:0] obs_ep;
    logic [15:0] obs_ve;

    always #5 clk = ~clk;

    nn_train_sequencer_if #(.BITS(16)) if_a ();
    nn_train_sequencer_if #(.BITS(16)) if_b ();
    nn_train_sequencer_if #(.BITS(4))  if_c ();

    assign if_a.GO = go & (sel == 0);
    assign if_b.GO = go & (sel == 1);
    assign if_c.GO = go & (sel == 2);
    assign if_a.TRAIN = tr_in;      assign if_a.VALID = vl_in;      assign if_a.EPOCH = ep_in;
    assign if_b.TRAIN = tr_in;      assign if_b.VALID = vl_in;      assign if_b.EPOCH = ep_in;
    assign if_c.TRAIN = tr_in[3:0]; assign if_c.VALID = vl_in[3:0]; assign if_c.EPOCH = ep_in[3:0];
    assign if_a.res_v = res_v; assign if_a.res_err = res_err;
    assign if_b.res_v = res_v; assign if_b.res_err = res_err;
    assign if_c.res_v = res_v; assign if_c.res_err = res_err;

    nn_train_sequencer #(.BITS(16), .SAMPLE_CYC(4)) u_dut_a (.clk(clk), .rst(rst), .bus(if_a));
    nn_train_sequencer #(.BITS(16), .SAMPLE_CYC(1)) u_dut_b (.clk(clk), .rst(rst), .bus(if_b));
    nn_train_sequencer #(.BITS(4),  .SAMPLE_CYC(2)) u_dut_c (.clk(clk), .rst(rst), .bus(if_c));

    always_comb begin
        obs_strb = 5'd0; obs_busy = 1'b0; obs_es = 1'b0; obs_ep = 16'd0; obs_ve = 16'd0;
        case (sel)
            0: begin
                obs_strb = {if_a.START, if_a.TR, if_a.VL, if_a.SW, if_a.END};
                obs_busy = if_a.busy; obs_es = if_a.early_stop;
                obs_ep = if_a.epoch_cnt; obs_ve = if_a.val_err;
            end
            1: begin
                obs_strb = {if_b.START, if_b.TR, if_b.VL, if_b.SW, if_b.END};
                obs_busy = if_b.busy; obs_es = if_b.early_stop;
                obs_ep = if_b.epoch_cnt; obs_ve = if_b.val_err;
            end
            2: begin
                obs_strb = {if_c.START, if_c.TR, if_c.VL, if_c.SW, if_c.END};
                obs_busy = if_c.busy; obs_es = if_c.early_stop;
                obs_ep = {12'd0, if_c.epoch_cnt}; obs_ve = {12'd0, if_c.val_err};
            end
            default: begin
                obs_strb = 5'd0;
            end
        endcase
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // 1 START, 2 TR, 3 VL, 4 SW, 5 END -> {START,TR,VL,SW,END}
    function automatic logic [4:0] code_vec(input int code);
        logic [4:0] v;
        case (code)
            1: v = 5'b10000;
            2: v = 5'b01000;
            3: v = 5'b00100;
            4: v = 5'b00010;
            5: v = 5'b00001;
            default: v = 5'b00000;
        endcase
        return v;
    endfunction

    // mode: 0 no results, 1 random results, 2 error every cycle, 3 fixed pattern
    task automatic run(input int s_i, input int t, input int v, input int e,
                       input int mode, input bit noise);
        int s;
        int c;
        int len;
        int errs;
        int cnt_ep;
        int last_err;
        int maxv;
        bit stop;
        bit es_exp;
        s    = (s_i == 0) ? 4 : ((s_i == 1) ? 1 : 2);
        maxv = (s_i == 2) ? 15 : 65535;
        sel   = s_i;
        tr_in = 16'(t);
        vl_in = 16'(v);
        ep_in = 16'(e);
        for (int i = 0; i < 1024; i++) begin
            exp_code[i] = 0;
            rv_a[i] = 1'b0;
            re_a[i] = 1'b0;
            if (mode == 1) begin
                rv_a[i] = 1'($urandom_range(0, 1));
                re_a[i] = 1'($urandom_range(0, 1));
            end else if (mode == 2) begin
                rv_a[i] = 1'b1;
                re_a[i] = 1'b1;
            end
        end
        if (mode == 3) begin
            rv_a[2] = 1'b1;  re_a[2] = 1'b1;
            rv_a[6] = 1'b1;
            rv_a[13] = 1'b1; re_a[13] = 1'b1;
            rv_a[15] = 1'b1; re_a[15] = 1'b1;
            rv_a[18] = 1'b1; re_a[18] = 1'b1;
        end
        // reference timeline: START, then per epoch T samples, V samples, SW, then END
        exp_code[0] = 1;
        c = 1; cnt_ep = 0; last_err = 0; stop = 1'b0; es_exp = 1'b0;
        for (int ep = 0; ep < e && !stop; ep++) begin
            for (int i = 0; i < t; i++) begin
                exp_code[c] = 2;
                c += s;
            end
            errs = 0;
            for (int i = 0; i < v; i++) begin
                exp_code[c] = 3;
                for (int k = 0; k < s; k++) begin
                    if (rv_a[c + k] && re_a[c + k]) errs++;
                end
                c += s;
            end
            exp_code[c] = 4;
            c++;
            cnt_ep++;
            last_err = (errs > maxv) ? maxv : errs;
`ifdef NN_EARLY_STOP_EN
            if (v != 0 && errs == 0) begin
                stop = 1'b1;
                es_exp = 1'b1;
            end
`endif
        end
        exp_code[c] = 5;
        len = c + 1;

        @(negedge clk);
        go = 1'b1;
        for (int cc = 0; cc < len; cc++) begin
            @(negedge clk);
            chk($sformatf("strobes sel%0d c%0d", s_i, cc), {11'd0, obs_strb},
                {11'd0, code_vec(exp_code[cc])});
            chk($sformatf("busy sel%0d c%0d", s_i, cc), {15'd0, obs_busy}, 16'd1);
            if (cc == len - 1) begin
                chk("epoch_cnt at END", obs_ep, 16'(cnt_ep));
                chk("val_err at END", obs_ve, 16'(last_err));
                chk("early_stop at END", {15'd0, obs_es}, {15'd0, es_exp});
            end
            go = (noise && cc < len - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            res_v   = rv_a[cc];
            res_err = re_a[cc];
        end
        @(negedge clk);
        res_v = 1'b0; res_err = 1'b0;
        chk("busy after END", {15'd0, obs_busy}, 16'd0);
        chk("strobes after END", {11'd0, obs_strb}, 16'd0);
        chk("epoch_cnt held", obs_ep, 16'(cnt_ep));
        @(negedge clk);
        chk("no restart", {11'd0, obs_strb}, 16'd0);
    endtask

    initial begin
        rst = 1'b1; go = 1'b0; res_v = 1'b0; res_err = 1'b0;
        tr_in = 16'd0; vl_in = 16'd0; ep_in = 16'd0; sel = 0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            sel = k;
            #1;
            chk("reset strobes", {11'd0, obs_strb}, 16'd0);
            chk("reset busy", {15'd0, obs_busy}, 16'd0);
            chk("reset epoch_cnt", obs_ep, 16'd0);
            chk("reset val_err", obs_ve, 16'd0);
            chk("reset early_stop", {15'd0, obs_es}, 16'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        run(0, 3, 2, 1, 3, 1'b0);
        run(1, 2, 2, 3, 1, 1'b0);
        run(0, 3, 2, 0, 0, 1'b0);
        run(2, 0, 1, 1, 0, 1'b0);
        run(2, 0, 10, 1, 2, 1'b0);

        // abort mid-training with a synchronous reset
        sel = 0; tr_in = 16'd3; vl_in = 16'd2; ep_in = 16'd1;
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
        @(negedge clk);
        @(negedge clk); res_v = 1'b1; res_err = 1'b1; rst = 1'b1;
        @(negedge clk); rst = 1'b0; res_v = 1'b0; res_err = 1'b0;
        chk("rst strobes", {11'd0, obs_strb}, 16'd0);
        chk("rst busy", {15'd0, obs_busy}, 16'd0);
        chk("rst epoch_cnt", obs_ep, 16'd0);
        chk("rst val_err", obs_ve, 16'd0);
        repeat (2) begin
            @(negedge clk);
            chk("idle after rst", {11'd0, obs_strb}, 16'd0);
        end

        run(0, 3, 2, 1, 3, 1'b1);
        run(0, 1, 1, 5, 0, 1'b0);

        for (int i = 0; i < 9; i++) begin
            run(i % 3, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nn_train_sequencer.md
Name: nn_train_sequencer

Overview:
- Control-side master for the pattern/data block.
- Generates the single-cycle START, TR, VL, SW and END strobes that step the data block through training and validation samples, epoch by epoch.
- Uses the TRAIN, VALID and EPOCH counts that the data block publishes.
- Counts validation errors reported by the architecture, and reports progress and completion.

Parameters:
- BITS, 16, width of the sample/epoch counts and counters.
- SAMPLE_CYC, 4, cycles allotted per sample (strobe-to-strobe spacing); legal range 1..255.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
- GO  input  1  run request; sampled only in IDLE.
- TRAIN  input  BITS  number of training samples per epoch.
- VALID  input  BITS  number of validation samples per epoch.
- EPOCH  input  BITS  number of epochs.
- res_v  input  1  architecture result strobe, one per processed sample.
- res_err  input  1  misclassification flag; qualified by res_v.
- START  output  1  process-start strobe to the data block.
- TR  output  1  training-sample strobe.
- VL  output  1  validation-sample strobe.
- SW  output  1  store-weights strobe.
- END  output  1  process-complete strobe.
- busy  output  1  high from the START cycle through the END cycle inclusive.
- epoch_cnt  output  BITS  number of completed epochs.
- val_err  output  BITS  validation error count of the current or last epoch.
- early_stop  output  1  run ended by early stop (feature only).

Behaviour:
- Reset: all strobes, busy and early_stop = 0; epoch_cnt = 0; val_err = 0; state = IDLE. Reset mid-run aborts immediately, and outputs take their reset values on the next edge.
- All strobes are registered outputs. At most one strobe is high in any cycle.
- FSM states: IDLE, STRT, TRN, VAL, STORE, FIN.
- IDLE: all strobes low. GO=1 → STRT. TRAIN, VALID and EPOCH are latched on this edge; later input changes are ignored until the next IDLE.
- STRT: START=1 for one cycle; epoch_cnt and val_err are cleared. Next state is FIN if EPOCH==0, else TRN.
- TRN:
  - Slot counter counts 0..SAMPLE_CYC-1; TR=1 in slot 0 of each sample.
  - Sample counter runs 0..TRAIN-1.
  - The state is left after the final slot of the final sample.
  - TRAIN==0 skips TRN entirely, with no TR pulse.
  - SAMPLE_CYC=1 gives TR continuously high for TRAIN cycles.
- VAL:
  - Same pacing as TRN, with VL instead of TR, for VALID samples.
  - val_err is cleared on entry.
  - val_err increments on each cycle with res_v & res_err while in VAL; it saturates at all-ones.
  - res_v outside VAL is ignored.
  - VALID==0 skips VAL and val_err stays 0.
- STORE: SW=1 for one cycle; epoch_cnt increments. Next state is FIN if epoch_cnt (new value) == EPOCH, else TRN.
- FIN: END=1 for one cycle → IDLE. busy falls the cycle after END.
- GO while busy: ignored. GO held high in IDLE starts one run per entry to IDLE.
- First TR occurs exactly 1 cycle after START. The first strobe of the next phase follows the last slot of the previous phase with no gap.
- Total run length for EPOCH=E, TRAIN=T, VALID=V, SAMPLE_CYC=S: 1 + E·(S·(T+V)+1) + 1 cycles (START cycle to END cycle inclusive).
- Counters are BITS wide. Slot and sample counters never wrap, because they compare against the latched limits.

Optional Feature:
- Macro: NN_EARLY_STOP_EN.
- When defined:
  - In STORE, if VALID!=0 and val_err==0, next state is FIN regardless of the remaining epochs.
  - early_stop is set on that transition and held until the next STRT or rst.
- When undefined: no early exit, and early_stop is tied 0.

Test Plan:
- Reset then GO, with T=3, V=2, E=1, S=4: START@c0; TR@c1,5,9; VL@c13,17; SW@c21; END@c22; epoch_cnt=1; busy 0 at c23.
- T=2, V=2, E=3, S=1: strobe sequence START,TR,TR,VL,VL,SW repeated 3 times, then END; 17 cycles total; epoch_cnt=3.
- E=0: START then END on the next cycle, no TR/VL/SW; T=0, V=1, E=1, S=2: VL@c1, SW@c3, END@c4.
- During VAL, drive res_v&res_err 3 times plus one res_v during TRN: val_err=3; saturation forced with BITS=4 and 20 errors gives val_err=15.
- rst asserted mid-TRN: all outputs 0 next cycle, state IDLE; GO during busy produces no restart.
- NN_EARLY_STOP_EN with E=5 and zero errors in epoch 1: END right after the first SW, epoch_cnt=1, early_stop=1; without the macro, 5 epochs run.
